// File: rtl/debounce_edge_detect_if.sv
// Handshake bundle between the upstream synchronizer side and the debouncer.
// The master drives the sampled level and counter clear; the slave returns debounced status.
interface debounce_edge_detect_if #(
  parameter int EVT_W = 8
);
  logic             i_data;
  logic             i_clr;
  logic             o_level;
  logic             o_rise;
  logic             o_fall;
  logic             o_busy;
  logic [EVT_W-1:0] o_press_cnt;

  modport master (
    output i_data,
    output i_clr,
    input  o_level,
    input  o_rise,
    input  o_fall,
    input  o_busy,
    input  o_press_cnt
  );

  modport slave (
    input  i_data,
    input  i_clr,
    output o_level,
    output o_rise,
    output o_fall,
    output o_busy,
    output o_press_cnt
  );
endinterface

// File: rtl/debounce_edge_detect.sv
// Single-bit debouncer: a level change is accepted after STABLE_CNT consecutive opposite
// samples; accepted changes produce one-cycle rise/fall pulses and rises are counted.
module debounce_edge_detect #(
  parameter int STABLE_CNT = 20,
  parameter int EVT_W      = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  debounce_edge_detect_if.slave       bus
);

  localparam int CW         = $clog2(STABLE_CNT + 1);
  localparam bit ACCEPT_NOW = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;
  logic [EVT_W-1:0] press_q;

  logic [31:0]      cnt_inc_d;
  logic             last_sample_d;
  logic [EVT_W-1:0] press_inc_d;
  logic [EVT_W-1:0] press_hold_d;

  // Qualification arithmetic done at full integer width so the compare against STABLE_CNT is exact.
  always_comb begin
    cnt_inc_d     = 32'(cnt_q) + 32'd1;
    last_sample_d = (cnt_inc_d == 32'(STABLE_CNT));
    press_inc_d   = bus.i_clr ? {EVT_W{1'b0}} : (press_q + EVT_W'(32'd1));
    press_hold_d  = bus.i_clr ? {EVT_W{1'b0}} : press_q;
  end

  // FSM, stability counter, registered outputs and press counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= LOW;
      cnt_q   <= {CW{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      press_q <= {EVT_W{1'b0}};
    end else begin
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= press_hold_d;
      case (state_q)
        LOW: begin
          if (bus.i_data && ACCEPT_NOW) begin
            state_q <= HIGH;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
            press_q <= press_inc_d;
          end else if (bus.i_data) begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CW'(32'd1);
            level_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= LOW;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (!bus.i_data) begin
            // Glitch: fall back without touching the level or pulses.
            state_q <= LOW;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (last_sample_d) begin
            state_q <= HIGH;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            busy_q  <= 1'b0;
            press_q <= press_inc_d;
          end else begin
            state_q <= WAIT_HIGH;
            cnt_q   <= CW'(cnt_inc_d);
            level_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (!bus.i_data && ACCEPT_NOW) begin
            state_q <= LOW;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (!bus.i_data) begin
            state_q <= WAIT_LOW;
            cnt_q   <= CW'(32'd1);
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= HIGH;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        WAIT_LOW: begin
          if (bus.i_data) begin
            state_q <= HIGH;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (last_sample_d) begin
            state_q <= LOW;
            cnt_q   <= {CW{1'b0}};
            level_q <= 1'b0;
            fall_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_LOW;
            cnt_q   <= CW'(cnt_inc_d);
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= {CW{1'b0}};
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_level     = level_q;
  assign bus.o_rise      = rise_q;
  assign bus.o_fall      = fall_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_press_cnt = press_q;

endmodule
